// File: rtl/entry_request_tx_pkg.sv
// Shared types and widths for the entry-interface requester.
package entry_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    localparam int FEAT_W = 3;
    localparam int AUTH_W = 3;
    localparam logic [FEAT_W-1:0] FEAT_NONE = 3'b000;

endpackage

// File: rtl/entry_request_tx_if.sv
// Board-pin and arbiter-side signals of one entry interface requester.
interface entry_request_tx_if;
    import entry_tx_pkg::*;

    logic              bt_sub_n;
    logic              bt_can_n;
    logic              key;
    logic [1:0]        pri;
    logic [FEAT_W-1:0] feat;
    logic              grant;
    logic              deny;
    logic              req;
    logic [AUTH_W-1:0] auth_out;
    logic [FEAT_W-1:0] feat_out;
    logic              led_act;
    logic              led_err;

    modport master (
        input  bt_sub_n, bt_can_n, key, pri, feat, grant, deny,
        output req, auth_out, feat_out, led_act, led_err
    );

    modport slave (
        output bt_sub_n, bt_can_n, key, pri, feat, grant, deny,
        input  req, auth_out, feat_out, led_act, led_err
    );

endinterface

// File: rtl/entry_request_tx_debounce_sync.sv
// Active-low button conditioner: 2-flop synchroniser, debounce counter and
// a one-cycle registered press pulse on the debounced 1->0 transition.
module debounce_sync #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic          meta, sync;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // NOTE: synchroniser resets to "pressed" and presses need a released
    // sample first, so a button held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= din_n;
            sync  <= meta;
            press <= 1'b0;
            if (sync)
                armed <= 1'b1;
            if (sync != level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    level <= sync;
                    cnt   <= '0;
                    press <= level & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/entry_request_tx.sv
// Entry-interface requester: conditions operator inputs and holds a request
// toward the arbiter. Define ENTRY_TX_TIMEOUT_EN to enable the REQUEST timeout.
module entry_request_tx
    import entry_tx_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BACKOFF_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    entry_request_tx_if.master bus
);

    localparam int BW = $clog2(BACKOFF_CYCLES) + 1;

    logic [5:0]        sw_meta, sw_sync;
    logic              key_s;
    logic [1:0]        pri_s;
    logic [FEAT_W-1:0] feat_s;
    logic              sub_press, can_press;

    state_t            state, state_d;
    logic              req_q, act_q, err_q, err_d;
    logic [AUTH_W-1:0] auth_q, auth_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic [BW-1:0]     bo_cnt;
    logic              bo_done, tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= {bus.key, bus.pri, bus.feat};
            sw_sync <= sw_meta;
        end
    end

    assign key_s  = sw_sync[5];
    assign pri_s  = sw_sync[4:3];
    assign feat_s = sw_sync[2:0];

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_sub (
        .clk(clk), .rst(rst), .din_n(bus.bt_sub_n), .press(sub_press)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_can (
        .clk(clk), .rst(rst), .din_n(bus.bt_can_n), .press(can_press)
    );

`ifdef ENTRY_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    // Cleared on entry to REQUEST; the hit lands on the TIMEOUT_CYCLES-th edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == REQUEST && state_d == REQUEST) begin
            if (!tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
        end else
            tmo_cnt <= '0;
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    assign bo_done = (bo_cnt == BW'(BACKOFF_CYCLES - 1));

    // NOTE: every always_comb output gets its default first so no latch forms.
    always_comb begin
        state_d = state;
        err_d   = err_q;
        auth_d  = auth_q;
        feat_d  = feat_q;
        case (state)
            IDLE: begin
                if (sub_press) begin
                    if (key_s && feat_s != FEAT_NONE) begin
                        auth_d  = {key_s, pri_s};
                        feat_d  = feat_s;
                        err_d   = 1'b0;
                        state_d = REQUEST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BACKOFF;
                    end
                end
            end
            REQUEST: begin
                if (can_press)
                    state_d = IDLE;
                else if (bus.grant)
                    state_d = ACTIVE;
                else if (bus.deny || tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = BACKOFF;
                end
            end
            ACTIVE: begin
                if (can_press || !bus.grant)
                    state_d = IDLE;
            end
            BACKOFF: begin
                if (bo_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            act_q  <= 1'b0;
            err_q  <= 1'b0;
            auth_q <= '0;
            feat_q <= '0;
            bo_cnt <= '0;
        end else begin
            state  <= state_d;
            req_q  <= (state_d == REQUEST) || (state_d == ACTIVE);
            act_q  <= (state_d == ACTIVE);
            err_q  <= err_d;
            auth_q <= auth_d;
            feat_q <= feat_d;
            if (state == BACKOFF && state_d == BACKOFF) begin
                if (!bo_done)
                    bo_cnt <= bo_cnt + 1'b1;
            end else
                bo_cnt <= '0;
        end
    end

    assign bus.req      = req_q;
    assign bus.led_act  = act_q;
    assign bus.led_err  = err_q;
    assign bus.auth_out = auth_q;
    assign bus.feat_out = feat_q;

endmodule

// File: tb/tb_entry_request_tx.sv
// Directed bench for entry_request_tx with a queue-based scoreboard.
// Expectations follow the ENTRY_TX_TIMEOUT_EN setting of the build.
module tb_entry_request_tx;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    typedef struct {
        string      tag;
        logic       req;
        logic [2:0] auth;
        logic [2:0] feat;
        logic       act;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    entry_request_tx_if bus ();

    entry_request_tx #(
        .DEB_CYCLES(4),
        .TIMEOUT_CYCLES(16),
        .BACKOFF_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [2:0] obs, logic [2:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string tag, logic r, logic [2:0] a, logic [2:0] f,
                              logic ac, logic e);
        exp_t x;
        x.tag = tag; x.req = r; x.auth = a; x.feat = f; x.act = ac; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic compare_out();
        exp_t x;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        x = exp_q.pop_front();
        check({x.tag, "_req"},  {2'b00, bus.req},     {2'b00, x.req});
        check({x.tag, "_auth"}, bus.auth_out,         x.auth);
        check({x.tag, "_feat"}, bus.feat_out,         x.feat);
        check({x.tag, "_act"},  {2'b00, bus.led_act}, {2'b00, x.act});
        check({x.tag, "_err"},  {2'b00, bus.led_err}, {2'b00, x.err});
    endtask

    // Push the expectation, advance n edges, then compare.
    task automatic step(int n, string tag, logic r, logic [2:0] a, logic [2:0] f,
                        logic ac, logic e);
        expect_out(tag, r, a, f, ac, e);
        tick(n);
        compare_out();
    endtask

    initial begin
        rst          = 1'b1;
        bus.bt_sub_n = 1'b1;
        bus.bt_can_n = 1'b1;
        bus.key      = 1'b0;
        bus.pri      = 2'b00;
        bus.feat     = 3'b000;
        bus.grant    = 1'b0;
        bus.deny     = 1'b0;

        expect_out("reset", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        #2;
        compare_out();
        tick(2);
        rst = 1'b0;
        tick(6);

        // Valid submit, grant, grant drop.
        bus.key = 1'b1; bus.pri = 2'b10; bus.feat = 3'b101;
        bus.bt_sub_n = 1'b0;
        step(6, "sub_edge6", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        step(1, "sub_edge7", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        tick(3);
        bus.bt_sub_n = 1'b1;
        bus.grant = 1'b1;
        step(1, "grant", 1'b1, 3'b110, 3'b101, 1'b1, 1'b0);
        bus.grant = 1'b0;
        step(1, "grant_drop", 1'b0, 3'b110, 3'b101, 1'b0, 1'b0);
        tick(10);

        // Three-cycle bounce is rejected by the debouncer.
        bus.bt_sub_n = 1'b0;
        tick(3);
        bus.bt_sub_n = 1'b1;
        step(10, "bounce", 1'b0, 3'b110, 3'b101, 1'b0, 1'b0);

        // Unauthorised submit goes to BACKOFF with LED_ERR.
        bus.key = 1'b0;
        bus.bt_sub_n = 1'b0;
        step(7, "no_key", 1'b0, 3'b110, 3'b101, 1'b0, 1'b1);
        bus.bt_sub_n = 1'b1;
        bus.key = 1'b1;
        step(8, "no_key_idle", 1'b0, 3'b110, 3'b101, 1'b0, 1'b1);
        tick(4);

        // Valid submit clears LED_ERR; DENY alone; press during BACKOFF dropped.
        bus.bt_sub_n = 1'b0;
        step(7, "deny_req", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        bus.bt_sub_n = 1'b1;
        tick(6);
        bus.bt_sub_n = 1'b0;
        bus.deny = 1'b1;
        step(1, "deny", 1'b0, 3'b110, 3'b101, 1'b0, 1'b1);
        bus.deny = 1'b0;
        step(12, "bo_press", 1'b0, 3'b110, 3'b101, 1'b0, 1'b1);
        bus.bt_sub_n = 1'b1;
        tick(10);

        // GRANT+DENY together: GRANT wins; switch changes do not leak; cancel.
        bus.pri = 2'b01;
        bus.bt_sub_n = 1'b0;
        step(7, "gd_req", 1'b1, 3'b101, 3'b101, 1'b0, 1'b0);
        bus.bt_sub_n = 1'b1;
        bus.grant = 1'b1; bus.deny = 1'b1;
        step(1, "gd_active", 1'b1, 3'b101, 3'b101, 1'b1, 1'b0);
        bus.feat = 3'b011; bus.pri = 2'b11;
        step(3, "active_hold", 1'b1, 3'b101, 3'b101, 1'b1, 1'b0);
        tick(2);
        bus.bt_can_n = 1'b0;
        step(6, "pre_cancel", 1'b1, 3'b101, 3'b101, 1'b1, 1'b0);
        step(1, "cancel", 1'b0, 3'b101, 3'b101, 1'b0, 1'b0);
        bus.bt_can_n = 1'b1;
        bus.grant = 1'b0; bus.deny = 1'b0;
        bus.feat = 3'b101; bus.pri = 2'b10;
        tick(10);

        // No response from the arbiter.
        bus.bt_sub_n = 1'b0;
        step(7, "tmo_req", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        bus.bt_sub_n = 1'b1;
`ifdef ENTRY_TX_TIMEOUT_EN
        step(15, "tmo_pre", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        step(1, "tmo_hit", 1'b0, 3'b110, 3'b101, 1'b0, 1'b1);
        tick(10);
`else
        step(100, "no_tmo", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        bus.bt_can_n = 1'b0;
        step(7, "no_tmo_cancel", 1'b0, 3'b110, 3'b101, 1'b0, 1'b0);
        bus.bt_can_n = 1'b1;
        tick(10);
`endif

        // Reset mid-request with the submit button held.
        bus.bt_sub_n = 1'b0;
        tick(7);
        expect_out("rst_async", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        compare_out();
        tick(1);
        rst = 1'b0;
        step(20, "held_after_rst", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        bus.bt_sub_n = 1'b1;
        tick(10);
        bus.bt_sub_n = 1'b0;
        step(7, "repress", 1'b1, 3'b110, 3'b101, 1'b0, 1'b0);
        bus.bt_sub_n = 1'b1;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
